// File: rtl/fighter_pkg.sv
// Shared fighter definitions: state encoding, sprite width and x clamping.
// Used by the fighter state machine and by the hit stage.
package fighter_pkg;

  localparam logic [3:0] ST_IDLE       = 4'd0;
  localparam logic [3:0] ST_MOVE_FWD   = 4'd1;
  localparam logic [3:0] ST_MOVE_BWD   = 4'd2;
  localparam logic [3:0] ST_STARTUP    = 4'd3;
  localparam logic [3:0] ST_ATTACK_ACT = 4'd6;
  localparam logic [3:0] ST_RECOVERY   = 4'd7;
  localparam logic [3:0] ST_STUN       = 4'd8;
  localparam logic [3:0] ST_BLOCKSTUN  = 4'd9;

  localparam int SPRITE_W = 64;
  localparam int CNT_W    = 6;

  function automatic logic signed [10:0] clamp_x(
    input logic signed [10:0] v,
    input logic signed [10:0] lo,
    input logic signed [10:0] hi
  );
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

endpackage

// File: rtl/fighter_fsm_edge_latch.sv
// Rising-edge detector with a request latch held until the next frame tick.
// Ports: clk, reset, sig (level in), clr (frame tick), req (pending request).
module edge_latch (
  input  logic clk,
  input  logic reset,
  input  logic sig,
  input  logic clr,
  output logic req
);
  import fighter_pkg::*;

  logic prev;
  logic armed;
  logic held;
  logic rise;

  // armed stays low for the first clock after reset so a level that is
  // already high at release is taken as history, not as an edge
  assign rise = armed & sig & ~prev;
  assign req  = held | rise;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev  <= 1'b0;
      armed <= 1'b0;
      held  <= 1'b0;
    end else begin
      prev  <= sig;
      armed <= 1'b1;
      held  <= clr ? 1'b0 : req;
    end
  end

endmodule

// File: rtl/fighter_fsm.sv
// Per-player fighter state machine: movement, attack phases and stun.
// Ports: clk, reset, frame_tick, btn_left/right/attack, opp_x, stun_in ->
// state, x, attacking, dir_attacking. Macro FIGHTER_BLOCK_EN adds blockstun.
module fighter_fsm #(
  parameter int         FACING       = 0,
  parameter logic [9:0] X_INIT       = 10'd100,
  parameter logic [9:0] X_MIN        = 10'd0,
  parameter logic [9:0] X_MAX        = 10'd576,
  parameter int         SPD_FWD      = 3,
  parameter int         SPD_BWD      = 2,
  parameter int         STARTUP      = 5,
  parameter int         ACTIVE       = 2,
  parameter int         RECOVERY     = 16,
  parameter int         DIR_STARTUP  = 4,
  parameter int         DIR_ACTIVE   = 3,
  parameter int         DIR_RECOVERY = 15,
  parameter int         STUN         = 30,
  parameter int         BLOCKSTUN    = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_attack,
  input  logic [9:0] opp_x,
  input  logic       stun_in,
  output logic [3:0] state,
  output logic [9:0] x,
  output logic       attacking,
  output logic       dir_attacking
);
  import fighter_pkg::*;

`ifdef FIGHTER_BLOCK_EN
  localparam logic BLOCK_EN = 1'b1;
`else
  localparam logic BLOCK_EN = 1'b0;
`endif

  localparam logic FLIP = (FACING != 0);

  logic             fwd;
  logic             bwd;
  logic             go_fwd;
  logic             go_bwd;
  logic             attack_req;
  logic             stun_req;
  logic [CNT_W-1:0] cnt;

  logic [3:0]       state_n;
  logic [9:0]       x_n;
  logic             atk_n;
  logic             dir_n;
  logic [CNT_W-1:0] cnt_n;
  logic             last;
  logic             neutral;

  assign fwd    = FLIP ? btn_left : btn_right;
  assign bwd    = FLIP ? btn_right : btn_left;
  assign go_fwd = fwd & ~bwd;
  assign go_bwd = bwd & ~fwd;

  edge_latch u_atk (
    .clk   (clk),
    .reset (reset),
    .sig   (btn_attack),
    .clr   (frame_tick),
    .req   (attack_req)
  );

  edge_latch u_stun (
    .clk   (clk),
    .reset (reset),
    .sig   (stun_in),
    .clr   (frame_tick),
    .req   (stun_req)
  );

  // candidate position if this frame is a move frame
  logic signed [10:0] xs;
  logic signed [10:0] mag;
  logic signed [10:0] sum;
  logic signed [10:0] cl;
  logic signed [11:0] cl12;
  logic signed [11:0] xs12;
  logic signed [11:0] lim;
  logic               plus;
  logic [9:0]         x_mv;

  always_comb begin
    xs   = signed'({1'b0, x});
    mag  = go_fwd ? signed'(11'(SPD_FWD)) : signed'(11'(SPD_BWD));
    plus = go_fwd ? ~FLIP : FLIP;
    sum  = plus ? xs + mag : xs - mag;
    cl   = clamp_x(sum, signed'({1'b0, X_MIN}), signed'({1'b0, X_MAX}));
    cl12 = {cl[10], cl};
    xs12 = {xs[10], xs};
    lim  = FLIP ? signed'({2'b00, opp_x}) + signed'(12'(SPRITE_W))
                : signed'({2'b00, opp_x}) - signed'(12'(SPRITE_W));
    x_mv = cl[9:0];
    // forward steps stop at the opponent's sprite; inside the gap we
    // hold rather than push back
    if (go_fwd) begin
      if (!FLIP) begin
        if (xs12 > lim) x_mv = x;
        else if (cl12 > lim) x_mv = lim[9:0];
      end else begin
        if (xs12 < lim) x_mv = x;
        else if (cl12 < lim) x_mv = lim[9:0];
      end
    end
  end

  always_comb begin
    state_n = state;
    x_n     = x;
    atk_n   = attacking;
    dir_n   = dir_attacking;
    cnt_n   = cnt;
    last    = (cnt == CNT_W'(1));
    neutral = (state == ST_IDLE) || (state == ST_MOVE_FWD) ||
              (state == ST_MOVE_BWD);
    if (stun_req) begin
      atk_n = 1'b0;
      dir_n = 1'b0;
      if (BLOCK_EN && state == ST_MOVE_BWD) begin
        state_n = ST_BLOCKSTUN;
        cnt_n   = CNT_W'(BLOCKSTUN);
      end else begin
        state_n = ST_STUN;
        cnt_n   = CNT_W'(STUN);
      end
    end else begin
      unique case (1'b1)
        neutral: begin
          if (attack_req) begin
            state_n = ST_STARTUP;
            cnt_n   = fwd ? CNT_W'(DIR_STARTUP) : CNT_W'(STARTUP);
            atk_n   = ~fwd;
            dir_n   = fwd;
          end else if (go_fwd) begin
            state_n = ST_MOVE_FWD;
            x_n     = x_mv;
          end else if (go_bwd) begin
            state_n = ST_MOVE_BWD;
            x_n     = x_mv;
          end else begin
            state_n = ST_IDLE;
          end
        end
        (state == ST_STARTUP): begin
          if (last) begin
            state_n = ST_ATTACK_ACT;
            cnt_n   = dir_attacking ? CNT_W'(DIR_ACTIVE) : CNT_W'(ACTIVE);
          end else begin
            cnt_n = cnt - CNT_W'(1);
          end
        end
        (state == ST_ATTACK_ACT): begin
          if (last) begin
            state_n = ST_RECOVERY;
            cnt_n   = dir_attacking ? CNT_W'(DIR_RECOVERY)
                                    : CNT_W'(RECOVERY);
          end else begin
            cnt_n = cnt - CNT_W'(1);
          end
        end
        (state == ST_RECOVERY): begin
          if (last) begin
            state_n = ST_IDLE;
            cnt_n   = '0;
            atk_n   = 1'b0;
            dir_n   = 1'b0;
          end else begin
            cnt_n = cnt - CNT_W'(1);
          end
        end
        (state == ST_STUN) || (state == ST_BLOCKSTUN): begin
          if (last) begin
            state_n = ST_IDLE;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt - CNT_W'(1);
          end
        end
        default: begin
          state_n = ST_IDLE;
          cnt_n   = '0;
          atk_n   = 1'b0;
          dir_n   = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= ST_IDLE;
      x             <= X_INIT;
      attacking     <= 1'b0;
      dir_attacking <= 1'b0;
      cnt           <= '0;
    end else if (frame_tick) begin
      state         <= state_n;
      x             <= x_n;
      attacking     <= atk_n;
      dir_attacking <= dir_n;
      cnt           <= cnt_n;
    end
  end

endmodule

// File: tb/tb_fighter_fsm.sv
// Self-checking bench for fighter_fsm (FACING=0, default parameters).
// Frame-level model plus directed scenarios with literal expectations.
module tb_fighter_fsm;

`ifdef FIGHTER_BLOCK_EN
  localparam bit BLOCK = 1'b1;
`else
  localparam bit BLOCK = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       frame_tick = 1'b0;
  logic       btn_left = 1'b0;
  logic       btn_right = 1'b0;
  logic       btn_attack = 1'b0;
  logic [9:0] opp_x = 10'd900;
  logic       stun_in = 1'b0;
  logic [3:0] state;
  logic [9:0] x;
  logic       attacking;
  logic       dir_attacking;

  int n_checks = 0;
  int n_fail = 0;

  fighter_fsm dut (
    .clk           (clk),
    .reset         (reset),
    .frame_tick    (frame_tick),
    .btn_left      (btn_left),
    .btn_right     (btn_right),
    .btn_attack    (btn_attack),
    .opp_x         (opp_x),
    .stun_in       (stun_in),
    .state         (state),
    .x             (x),
    .attacking     (attacking),
    .dir_attacking (dir_attacking)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int req_v);
    n_checks++;
    if (act != req_v) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, req_v,
               $time);
    end
  endtask

  // ---------------- frame-level model ----------------
  // mode 0 = neutral (mv: 0 idle, 1 fwd, 2 bwd), 1 = attack timeline,
  // 2 = stun countdown
  int m_mode, m_mv, m_age, m_left, m_x;
  bit m_dir, m_blk;
  bit m_armed, m_pa, m_ps, m_areq, m_sreq;

  function automatic int atk_len(bit d, int ph);
    int s, a, r;
    s = d ? 4 : 5;
    a = d ? 3 : 2;
    r = d ? 15 : 16;
    return ph == 0 ? s : ph == 1 ? a : r;
  endfunction

  function automatic int exp_state();
    if (m_mode == 0) return m_mv;
    if (m_mode == 2) return m_blk ? 9 : 8;
    if (m_age < atk_len(m_dir, 0)) return 3;
    if (m_age < atk_len(m_dir, 0) + atk_len(m_dir, 1)) return 6;
    return 7;
  endfunction

  function automatic int move_x(int cur, bit f, int opp);
    int n, lim;
    n = f ? cur + 3 : cur - 2;
    if (n < 0) n = 0;
    if (n > 576) n = 576;
    if (f) begin
      lim = opp - 64;
      if (cur > lim) n = cur;
      else if (n > lim) n = lim;
    end
    return n;
  endfunction

  task automatic m_frame(bit a, bit s);
    bit f, b;
    f = btn_right;
    b = btn_left;
    if (s) begin
      m_blk  = BLOCK && m_mode == 0 && m_mv == 2;
      m_mode = 2;
      m_left = m_blk ? 10 : 30;
    end else if (m_mode == 0) begin
      if (a) begin
        m_mode = 1;
        m_age  = 0;
        m_dir  = f;
      end else begin
        m_mv = (f && !b) ? 1 : (b && !f) ? 2 : 0;
        if (m_mv != 0) m_x = move_x(m_x, m_mv == 1, int'(opp_x));
      end
    end else if (m_mode == 1) begin
      m_age++;
      if (m_age == atk_len(m_dir, 0) + atk_len(m_dir, 1) +
                   atk_len(m_dir, 2)) begin
        m_mode = 0;
        m_mv   = 0;
      end
    end else begin
      m_left--;
      if (m_left == 0) begin
        m_mode = 0;
        m_mv   = 0;
      end
    end
  endtask

  always @(posedge clk or posedge reset) begin
    bit ae, se, an, sn;
    if (reset) begin
      m_mode = 0; m_mv = 0; m_age = 0; m_left = 0; m_x = 100;
      m_dir = 0; m_blk = 0;
      m_armed = 0; m_pa = 0; m_ps = 0; m_areq = 0; m_sreq = 0;
    end else begin
      ae = m_armed && btn_attack && !m_pa;
      se = m_armed && stun_in && !m_ps;
      an = m_areq || ae;
      sn = m_sreq || se;
      m_pa = btn_attack;
      m_ps = stun_in;
      m_armed = 1;
      if (frame_tick) begin
        m_frame(an, sn);
        m_areq = 0;
        m_sreq = 0;
      end else begin
        m_areq = an;
        m_sreq = sn;
      end
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      chk("model_state", int'(state), exp_state());
      chk("model_x", int'(x), m_x);
      chk("model_attacking", int'(attacking), int'(m_mode == 1 && !m_dir));
      chk("model_dir_attacking", int'(dir_attacking),
          int'(m_mode == 1 && m_dir));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic frame();
    repeat (2) @(negedge clk);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
  endtask

  task automatic expect_frames(input string nm, input int st, input int atk,
                               input int dat, input int n);
    for (int i = 0; i < n; i++) begin
      frame();
      chk({nm, "_state"}, int'(state), st);
      chk({nm, "_atk"}, int'(attacking), atk);
      chk({nm, "_dir"}, int'(dir_attacking), dat);
    end
  endtask

  task automatic pulse_attack();
    @(negedge clk);
    btn_attack = 1'b1;
    @(negedge clk);
    btn_attack = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_state", int'(state), 0);
    chk("reset_x", int'(x), 100);
    chk("reset_atk", int'(attacking), 0);
    chk("reset_dir", int'(dir_attacking), 0);
    reset = 1'b0;

    // plain attack from idle
    expect_frames("idle", 0, 0, 0, 3);
    pulse_attack();
    expect_frames("plain_startup", 3, 1, 0, 5);
    expect_frames("plain_active", 6, 1, 0, 2);
    expect_frames("plain_recovery", 7, 1, 0, 16);
    expect_frames("plain_done", 0, 0, 0, 1);

    // directional attack with forward held
    @(negedge clk);
    btn_right = 1'b1;
    pulse_attack();
    expect_frames("dir_startup", 3, 0, 1, 4);
    expect_frames("dir_active", 6, 0, 1, 3);
    expect_frames("dir_recovery", 7, 0, 1, 14);
    btn_right = 1'b0;
    expect_frames("dir_recovery_end", 7, 0, 1, 1);
    expect_frames("dir_done", 0, 0, 0, 1);
    chk("dir_x_unmoved", int'(x), 100);

    // stun during active frames
    pulse_attack();
    expect_frames("stun_pre_startup", 3, 1, 0, 5);
    expect_frames("stun_pre_active", 6, 1, 0, 1);
    @(negedge clk);
    stun_in = 1'b1;
    expect_frames("stun", 8, 0, 0, 30);
    expect_frames("stun_done", 0, 0, 0, 1);
    stun_in = 1'b0;

    // stun while walking back
    @(negedge clk);
    btn_left = 1'b1;
    expect_frames("walk_back", 2, 0, 0, 1);
    chk("walk_back_x", int'(x), 98);
    btn_left = 1'b0;
    stun_in = 1'b1;
    if (BLOCK) expect_frames("blockstun", 9, 0, 0, 10);
    else expect_frames("bwd_stun", 8, 0, 0, 30);
    expect_frames("bwd_stun_done", 0, 0, 0, 1);
    chk("bwd_stun_x", int'(x), 98);
    stun_in = 1'b0;

    // reset mid-recovery with stun held high
    pulse_attack();
    expect_frames("rst_pre", 3, 1, 0, 5);
    expect_frames("rst_pre_act", 6, 1, 0, 2);
    expect_frames("rst_pre_rec", 7, 1, 0, 3);
    @(negedge clk);
    stun_in = 1'b1;
    #2 reset = 1'b1;
    #1;
    chk("async_reset_state", int'(state), 0);
    chk("async_reset_x", int'(x), 100);
    chk("async_reset_atk", int'(attacking), 0);
    @(negedge clk);
    reset = 1'b0;
    expect_frames("no_stun_after_reset", 0, 0, 0, 3);
    stun_in = 1'b0;

    // walk forward to 502, back to 500, then into the opponent gap
    @(negedge clk);
    btn_right = 1'b1;
    opp_x = 10'd900;
    for (int i = 0; i < 134; i++) frame();
    chk("walk_fwd_x", int'(x), 502);
    btn_right = 1'b0;
    btn_left = 1'b1;
    frame();
    chk("walk_back_500", int'(x), 500);
    btn_left = 1'b0;
    btn_right = 1'b1;
    opp_x = 10'd566;
    for (int i = 0; i < 5; i++) begin
      frame();
      chk("gap_clamp_x", int'(x), 502);
      chk("gap_state", int'(state), 1);
    end

    // clamp at X_MAX with a distant opponent
    opp_x = 10'd1000;
    for (int i = 0; i < 30; i++) frame();
    chk("xmax_clamp", int'(x), 576);

    // both directions held -> idle
    btn_left = 1'b1;
    frame();
    chk("both_held_state", int'(state), 0);
    chk("both_held_x", int'(x), 576);
    btn_left = 1'b0;
    btn_right = 1'b0;
    frame();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fighter_fsm.md
FIGHTER_FSM -- requirements
Module: fighter_fsm

Interface
REQ-001 SHALL have parameter FACING, default 0, meaning 0 = faces right (player 1), 1 = faces left (player 2).
REQ-002 SHALL have parameters X_INIT 10'd100, X_MIN 10'd0, X_MAX 10'd576, SPD_FWD 3, SPD_BWD 2 (pixels per frame).
REQ-003 SHALL have parameters STARTUP 5, ACTIVE 2, RECOVERY 16, DIR_STARTUP 4, DIR_ACTIVE 3, DIR_RECOVERY 15, STUN 30, BLOCKSTUN 10 (frames, 1..63).
REQ-004 SHALL have ports: clk in 1, clock; reset in 1, asynchronous, active-high.
REQ-005 SHALL have ports: frame_tick in 1, one-clk pulse per video frame; btn_left, btn_right, btn_attack in 1, debounced, active-high.
REQ-006 SHALL have ports: opp_x in 10, opponent left edge; stun_in in 1, sticky stun level for this player from the hit stage.
REQ-007 SHALL have ports: state out 4, encoded state; x out 10, own left edge; attacking out 1; dir_attacking out 1.

Function
REQ-008 SHALL use the encoding IDLE 0, MOVE_FWD 1, MOVE_BWD 2, STARTUP 3, ATTACK_ACT 6, RECOVERY 7, STUN 8, BLOCKSTUN 9.
REQ-009 SHALL map fwd = btn_right, bwd = btn_left when FACING=0, and the reverse when FACING=1.
REQ-010 SHALL latch a rising edge of btn_attack on any clk into attack_req, cleared on the next frame_tick.
REQ-011 SHALL latch a rising edge of stun_in on any clk into stun_req, cleared on the next frame_tick.
REQ-012 SHALL change state, x and frame counter only on clk cycles with frame_tick=1, with registered outputs valid the following cycle.
REQ-013 SHALL give stun_req top priority: from any state, enter STUN with counter = STUN.
REQ-014 SHALL, in IDLE/MOVE_FWD/MOVE_BWD, start an attack on attack_req: enter STARTUP and load the counter from the DIR_* set if fwd is held, otherwise from the plain set.
REQ-015 SHALL, with no attack_req, select MOVE_FWD if only fwd is held, MOVE_BWD if only bwd is held, and IDLE otherwise (including both held).
REQ-016 SHALL step STARTUP->ATTACK_ACT->RECOVERY->IDLE, and STUN/BLOCKSTUN->IDLE, when the counter is 1; otherwise decrement the counter.
REQ-017 SHALL ignore attack_req outside IDLE and the two MOVE states, with no buffering.
REQ-018 SHALL hold attacking=1 from STARTUP entry through RECOVERY exit for plain attacks, and dir_attacking=1 over the same span for directional attacks (mutually exclusive).
REQ-019 SHALL move only in MOVE_FWD and MOVE_BWD, by SPD_FWD or SPD_BWD per frame, forward = +x for FACING=0.
REQ-020 SHALL compute movement in 11-bit signed arithmetic and clamp the result to [X_MIN, X_MAX].
REQ-021 SHALL also clamp forward motion to x <= opp_x-64 (FACING=0) or x >= opp_x+64 (FACING=1); when already inside the gap, hold x with no backward push.

Reset
REQ-022 SHALL on reset set state=IDLE, x=X_INIT, attacking=0, dir_attacking=0, counter=0, attack_req=0, stun_req=0, and clear both edge-detect history registers to 0.
REQ-023 SHALL, if stun_in is already 1 at reset release, not treat it as an edge.

Configuration
REQ-024 SHALL with FIGHTER_BLOCK_EN defined redirect a stun_req arriving while in MOVE_BWD to BLOCKSTUN with counter = BLOCKSTUN and no x change.
REQ-025 SHALL without FIGHTER_BLOCK_EN never enter BLOCKSTUN, treating every stun_req per REQ-013.

Structure
REQ-026 SHALL place the state encoding localparams and the 64-pixel sprite width constant in the shared package fighter_pkg, also used by the hit stage.
REQ-027 SHALL implement the two edge-detect-and-latch units (REQ-010/011) as sub-module edge_latch, instantiated twice.

Verification
REQ-028 SHALL cover: FACING=0, attack pulse, 3 frames idle -> state 3 for 5 frames, 6 for 2, 7 for 16, then 0; attacking=1 for exactly 23 frames.
REQ-029 SHALL cover: btn_right held with attack pulse -> dir_attacking=1, attacking=0, ATTACK_ACT for 3 frames.
REQ-030 SHALL cover: x=500, opp_x=566, btn_right held 5 frames -> x=502 then holds at 502.
REQ-031 SHALL cover: stun_in rises during ATTACK_ACT -> STUN at next tick for 30 frames, then IDLE, attacking drops at STUN entry.
REQ-032 SHALL cover: FIGHTER_BLOCK_EN defined, MOVE_BWD, stun_in rises -> state 9 for 10 frames; undefined -> state 8 for 30.
REQ-033 SHALL cover: reset asserted mid-RECOVERY with stun_in=1 -> state 0, x=X_INIT immediately, no STUN after release.
